// File: rtl/enc_pack_scheduler_if.sv
// Interface bundling the encoder pack scheduler's control and handshake signals.
// master: the scheduler side. slave: the encoder-top side (level memory,
// binder packs, accumulator).
// Optional feature macro: ENC_SCHED_ABORT_EN adds enc_abort / enc_aborted.
interface enc_pack_scheduler_if #(
   parameter int NUM_PACKS = 16,
   parameter int PACK_W    = $clog2(NUM_PACKS) + 1
);
   // pass control
   logic                 enc_start;
   logic                 enc_busy;
   logic                 enc_done;
   // level-HV fetch
   logic                 lvl_req;
   logic [PACK_W-1:0]    lvl_idx;
   logic                 lvl_valid;
   // binder pack triggers
   logic [NUM_PACKS-1:0] pack_start;
   // accumulator handoff
   logic                 acc_valid;
   logic [PACK_W-1:0]    acc_idx;
   logic                 acc_last;
   logic                 acc_ready;
`ifdef ENC_SCHED_ABORT_EN
   logic                 enc_abort;
   logic                 enc_aborted;

   modport master (
      input  enc_start, lvl_valid, acc_ready, enc_abort,
      output enc_busy, enc_done, lvl_req, lvl_idx, pack_start,
             acc_valid, acc_idx, acc_last, enc_aborted
   );

   modport slave (
      output enc_start, lvl_valid, acc_ready, enc_abort,
      input  enc_busy, enc_done, lvl_req, lvl_idx, pack_start,
             acc_valid, acc_idx, acc_last, enc_aborted
   );
`else
   modport master (
      input  enc_start, lvl_valid, acc_ready,
      output enc_busy, enc_done, lvl_req, lvl_idx, pack_start,
             acc_valid, acc_idx, acc_last
   );

   modport slave (
      output enc_start, lvl_valid, acc_ready,
      input  enc_busy, enc_done, lvl_req, lvl_idx, pack_start,
             acc_valid, acc_idx, acc_last
   );
`endif
endinterface

// File: rtl/enc_pack_scheduler.sv
// Encoder pack scheduler: walks the binder packs one at a time for one
// encoding pass. For each pack it requests the level HVs, fires that pack's
// start_encoding, waits out the binder latency, then offers the shifted HVs
// to the bundling accumulator over valid/ready.
// Optional feature macro: ENC_SCHED_ABORT_EN adds an abort input that drops
// the pass back to IDLE and a one-cycle enc_aborted pulse.
module enc_pack_scheduler #(
   parameter int NUM_PACKS = 16,
   parameter int BIND_LAT  = 1,
   parameter int PACK_W    = $clog2(NUM_PACKS) + 1
) (
   input  logic                clk,
   input  logic                nrst,
   enc_pack_scheduler_if.master bus
);

   // Wait counter only needs to reach BIND_LAT-1; keep at least one bit.
   localparam int                WAIT_W    = (BIND_LAT > 1) ? $clog2(BIND_LAT) : 1;
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(BIND_LAT - 1);
   localparam logic [PACK_W-1:0] LAST_IDX  = PACK_W'(NUM_PACKS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_BIND  = 3'd2,
      S_PUSH  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_reg;
   state_t               state_next;
   logic [PACK_W-1:0]    idx_reg;
   logic [PACK_W-1:0]    idx_next;
   logic [WAIT_W-1:0]    wait_reg;
   logic [WAIT_W-1:0]    wait_next;

   // Output registers; their next values are decoded from the next state so
   // every output (except lvl_req / acc_last) comes straight off a flop.
   logic                 busy_reg;
   logic                 busy_next;
   logic                 done_reg;
   logic                 done_next;
   logic                 acc_valid_reg;
   logic                 acc_valid_next;
   logic [NUM_PACKS-1:0] pack_start_reg;
   logic [NUM_PACKS-1:0] pack_start_next;
   logic                 enter_bind;
   logic                 abort_hit;

`ifdef ENC_SCHED_ABORT_EN
   logic                 aborted_reg;

   // Abort is honoured only while a pack is being worked on; in DONE the
   // pass has already completed and enc_done wins.
   assign abort_hit = bus.enc_abort &&
                      ((state_reg == S_FETCH) || (state_reg == S_BIND) || (state_reg == S_PUSH));
`else
   assign abort_hit = 1'b0;
`endif

   // State, pack index and binder wait counter.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg <= S_IDLE;
         idx_reg   <= '0;
         wait_reg  <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         wait_reg  <= wait_next;
      end
   end

   // Next-state logic: one pack at a time, FETCH -> BIND -> PUSH, then DONE.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      wait_next  = wait_reg;

      case (state_reg)
         S_IDLE: begin
            idx_next  = '0;
            wait_next = '0;
            if (bus.enc_start) begin
               state_next = S_FETCH;
            end
         end

         S_FETCH: begin
            if (bus.lvl_valid) begin
               state_next = S_BIND;
               wait_next  = '0;
            end
         end

         S_BIND: begin
            if (wait_reg == LAST_WAIT) begin
               state_next = S_PUSH;
               wait_next  = '0;
            end else begin
               wait_next = wait_reg + WAIT_W'(1);
            end
         end

         S_PUSH: begin
            if (bus.acc_ready) begin
               // The last pack leaves through DONE so idx never wraps.
               if (idx_reg == LAST_IDX) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_FETCH;
                  idx_next   = idx_reg + PACK_W'(1);
               end
            end
         end

         S_DONE: begin
            state_next = S_IDLE;
            idx_next   = '0;
         end

         default: begin
            state_next = S_IDLE;
            idx_next   = '0;
            wait_next  = '0;
         end
      endcase

      // Abort overrides everything, including a same-cycle acc_ready.
      if (abort_hit) begin
         state_next = S_IDLE;
         idx_next   = '0;
         wait_next  = '0;
      end
   end

   // Output next values, decoded from where the FSM is heading.
   always_comb begin
      busy_next      = 1'b0;
      done_next      = 1'b0;
      acc_valid_next = 1'b0;
      enter_bind     = 1'b0;

      busy_next      = (state_next != S_IDLE);
      done_next      = (state_next == S_DONE);
      acc_valid_next = (state_next == S_PUSH);
      // start_encoding only on the first BIND cycle of each pack.
      enter_bind     = (state_next == S_BIND) && (state_reg != S_BIND);
   end

   // One-hot pack trigger: bit gi fires when pack gi enters BIND.
   generate
      for (genvar gi = 0; gi < NUM_PACKS; gi++) begin : g_pack_start
         assign pack_start_next[gi] = enter_bind && (idx_next == PACK_W'(gi));
      end
   endgenerate

   // Registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         acc_valid_reg  <= 1'b0;
         pack_start_reg <= '0;
      end else begin
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         acc_valid_reg  <= acc_valid_next;
         pack_start_reg <= pack_start_next;
      end
   end

`ifdef ENC_SCHED_ABORT_EN
   // One-cycle pulse in the IDLE cycle that follows an accepted abort.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         aborted_reg <= 1'b0;
      end else begin
         aborted_reg <= abort_hit;
      end
   end

   assign bus.enc_aborted = aborted_reg;
`endif

   assign bus.enc_busy   = busy_reg;
   assign bus.enc_done   = done_reg;
   assign bus.pack_start = pack_start_reg;
   assign bus.acc_valid  = acc_valid_reg;
   // idx is held at 0 whenever the FSM sits in IDLE, so both index outputs
   // read 0 there and show the current pack everywhere else.
   assign bus.lvl_idx    = idx_reg;
   assign bus.acc_idx    = idx_reg;
   assign bus.lvl_req    = (state_reg == S_FETCH);
   assign bus.acc_last   = (state_reg == S_PUSH) && (idx_reg == LAST_IDX);

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// Directed bench for enc_pack_scheduler, NUM_PACKS=4, BIND_LAT=1.
// Cycle 0 of each scenario is the cycle in which enc_start is driven; inputs
// change 1 time unit after the rising edge, outputs are sampled on the
// falling edge. With ENC_SCHED_ABORT_EN defined, a second instance with
// BIND_LAT=3 exercises the abort path.
module tb_enc_pack_scheduler;
   localparam int NP   = 4;
   localparam int PW   = $clog2(NP) + 1;
   localparam int MAXC = 32;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   enc_pack_scheduler_if #(.NUM_PACKS(NP)) bus ();
   enc_pack_scheduler #(.NUM_PACKS(NP), .BIND_LAT(1)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

`ifdef ENC_SCHED_ABORT_EN
   enc_pack_scheduler_if #(.NUM_PACKS(NP)) bus3 ();
   enc_pack_scheduler #(.NUM_PACKS(NP), .BIND_LAT(3)) dut3 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus3)
   );
`endif

   // per-cycle stimulus
   logic st_start [MAXC];
   logic st_lvl   [MAXC];
   logic st_rdy   [MAXC];
   logic st_nrst  [MAXC];
   // per-cycle recorded outputs
   logic          r_busy [MAXC];
   logic          r_done [MAXC];
   logic          r_lreq [MAXC];
   logic          r_accv [MAXC];
   logic          r_last [MAXC];
   logic [NP-1:0] r_ps   [MAXC];
   logic [PW-1:0] r_lidx [MAXC];
   logic [PW-1:0] r_aidx [MAXC];

   task automatic clear_stim();
      for (int c = 0; c < MAXC; c++) begin
         st_start[c] = 1'b0;
         st_lvl[c]   = 1'b1;
         st_rdy[c]   = 1'b1;
         st_nrst[c]  = 1'b1;
      end
   endtask

   // Plays the stimulus vectors for n cycles and records the outputs.
   task automatic run_cycles(input string name, input int n);
      for (int c = 0; c < n; c++) begin
         bus.enc_start = st_start[c];
         bus.lvl_valid = st_lvl[c];
         bus.acc_ready = st_rdy[c];
         nrst          = st_nrst[c];
         @(negedge clk);
         r_busy[c] = bus.enc_busy;
         r_done[c] = bus.enc_done;
         r_lreq[c] = bus.lvl_req;
         r_accv[c] = bus.acc_valid;
         r_last[c] = bus.acc_last;
         r_ps[c]   = bus.pack_start;
         r_lidx[c] = bus.lvl_idx;
         r_aidx[c] = bus.acc_idx;
         if (bus.acc_valid && bus.acc_ready)
            $display("%s cycle %0d: pack %0d accepted last=%0b", name, c, bus.acc_idx, bus.acc_last);
         @(posedge clk);
         #1;
      end
      bus.enc_start = 1'b0;
      bus.lvl_valid = 1'b1;
      bus.acc_ready = 1'b1;
      nrst          = 1'b1;
   endtask

   task automatic test_reset();
      nrst          = 1'b0;
      bus.enc_start = 1'b1;
      bus.lvl_valid = 1'b1;
      bus.acc_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 8;
      if (bus.enc_busy   !== 1'b0) begin errors++; $display("FAIL reset.busy got=%0b exp=0", bus.enc_busy); end
      if (bus.enc_done   !== 1'b0) begin errors++; $display("FAIL reset.done got=%0b exp=0", bus.enc_done); end
      if (bus.lvl_req    !== 1'b0) begin errors++; $display("FAIL reset.lvl_req got=%0b exp=0", bus.lvl_req); end
      if (bus.acc_valid  !== 1'b0) begin errors++; $display("FAIL reset.acc_valid got=%0b exp=0", bus.acc_valid); end
      if (bus.acc_last   !== 1'b0) begin errors++; $display("FAIL reset.acc_last got=%0b exp=0", bus.acc_last); end
      if (bus.pack_start !== '0)   begin errors++; $display("FAIL reset.pack_start got=%b exp=0", bus.pack_start); end
      if (bus.lvl_idx    !== '0)   begin errors++; $display("FAIL reset.lvl_idx got=%0d exp=0", bus.lvl_idx); end
      if (bus.acc_idx    !== '0)   begin errors++; $display("FAIL reset.acc_idx got=%0d exp=0", bus.acc_idx); end
      @(posedge clk);
      #1;
      bus.enc_start = 1'b0;
      nrst          = 1'b1;
      @(negedge clk);
      checks += 3;
      if (bus.enc_busy   !== 1'b0) begin errors++; $display("FAIL reset.release_busy got=%0b exp=0", bus.enc_busy); end
      if (bus.lvl_req    !== 1'b0) begin errors++; $display("FAIL reset.release_lvl_req got=%0b exp=0", bus.lvl_req); end
      if (bus.pack_start !== '0)   begin errors++; $display("FAIL reset.release_pack_start got=%b exp=0", bus.pack_start); end
      @(posedge clk);
      #1;
      $display("test_reset done");
   endtask

   task automatic test_nominal();
      int e_busy [16];
      int e_done [16];
      int e_lreq [16];
      int e_accv [16];
      int e_last [16];
      int e_ps   [16];
      int e_idx  [16];
      e_busy = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
      e_done = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0};
      e_lreq = '{0,1,0,0,1,0,0,1,0,0,1,0,0,0,0,0};
      e_accv = '{0,0,0,1,0,0,1,0,0,1,0,0,1,0,0,0};
      e_last = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0};
      e_ps   = '{0,0,1,0,0,2,0,0,4,0,0,8,0,0,0,0};
      e_idx  = '{0,0,0,0,1,1,1,2,2,2,3,3,3,3,0,0};
      clear_stim();
      st_start[0] = 1'b1;
      run_cycles("nominal", 16);
      for (int c = 0; c < 16; c++) begin
         checks += 8;
         if (r_busy[c] !== e_busy[c][0]) begin errors++; $display("FAIL nominal.busy cyc=%0d got=%0b exp=%0b", c, r_busy[c], e_busy[c][0]); end
         if (r_done[c] !== e_done[c][0]) begin errors++; $display("FAIL nominal.done cyc=%0d got=%0b exp=%0b", c, r_done[c], e_done[c][0]); end
         if (r_lreq[c] !== e_lreq[c][0]) begin errors++; $display("FAIL nominal.lvl_req cyc=%0d got=%0b exp=%0b", c, r_lreq[c], e_lreq[c][0]); end
         if (r_accv[c] !== e_accv[c][0]) begin errors++; $display("FAIL nominal.acc_valid cyc=%0d got=%0b exp=%0b", c, r_accv[c], e_accv[c][0]); end
         if (r_last[c] !== e_last[c][0]) begin errors++; $display("FAIL nominal.acc_last cyc=%0d got=%0b exp=%0b", c, r_last[c], e_last[c][0]); end
         if (r_ps[c] !== e_ps[c][NP-1:0]) begin errors++; $display("FAIL nominal.pack_start cyc=%0d got=%b exp=%b", c, r_ps[c], e_ps[c][NP-1:0]); end
         if (r_lidx[c] !== e_idx[c][PW-1:0]) begin errors++; $display("FAIL nominal.lvl_idx cyc=%0d got=%0d exp=%0d", c, r_lidx[c], e_idx[c][PW-1:0]); end
         if (r_aidx[c] !== e_idx[c][PW-1:0]) begin errors++; $display("FAIL nominal.acc_idx cyc=%0d got=%0d exp=%0d", c, r_aidx[c], e_idx[c][PW-1:0]); end
      end
      $display("test_nominal done");
   endtask

   task automatic test_acc_stall();
      logic [PW-1:0] one_idx = PW'(1);
      clear_stim();
      st_start[0] = 1'b1;
      for (int c = 6; c <= 10; c++) st_rdy[c] = 1'b0;
      run_cycles("acc_stall", 22);
      for (int c = 6; c <= 11; c++) begin
         checks += 2;
         if (r_accv[c] !== 1'b1)    begin errors++; $display("FAIL acc_stall.acc_valid cyc=%0d got=%0b exp=1", c, r_accv[c]); end
         if (r_aidx[c] !== one_idx) begin errors++; $display("FAIL acc_stall.acc_idx cyc=%0d got=%0d exp=1", c, r_aidx[c]); end
      end
      checks += 3;
      if (r_accv[12] !== 1'b0)    begin errors++; $display("FAIL acc_stall.valid_drop got=%0b exp=0", r_accv[12]); end
      if (r_ps[13] !== 4'b0100)   begin errors++; $display("FAIL acc_stall.ps2 got=%b exp=0100", r_ps[13]); end
      if (r_ps[16] !== 4'b1000)   begin errors++; $display("FAIL acc_stall.ps3 got=%b exp=1000", r_ps[16]); end
      for (int c = 0; c < 22; c++) begin
         checks++;
         if (r_done[c] !== (c == 18)) begin errors++; $display("FAIL acc_stall.done cyc=%0d got=%0b exp=%0b", c, r_done[c], (c == 18)); end
      end
      $display("test_acc_stall done");
   endtask

   task automatic test_lvl_stall();
      logic [PW-1:0] two_idx = PW'(2);
      int            ps2_count = 0;
      clear_stim();
      st_start[0] = 1'b1;
      for (int c = 7; c <= 9; c++) st_lvl[c] = 1'b0;
      run_cycles("lvl_stall", 20);
      for (int c = 7; c <= 10; c++) begin
         checks += 2;
         if (r_lreq[c] !== 1'b1)    begin errors++; $display("FAIL lvl_stall.lvl_req cyc=%0d got=%0b exp=1", c, r_lreq[c]); end
         if (r_lidx[c] !== two_idx) begin errors++; $display("FAIL lvl_stall.lvl_idx cyc=%0d got=%0d exp=2", c, r_lidx[c]); end
      end
      for (int c = 0; c < 20; c++) if (r_ps[c][2] === 1'b1) ps2_count++;
      checks += 4;
      if (ps2_count != 1)        begin errors++; $display("FAIL lvl_stall.ps2_count got=%0d exp=1", ps2_count); end
      if (r_ps[11] !== 4'b0100)  begin errors++; $display("FAIL lvl_stall.ps2_late got=%b exp=0100", r_ps[11]); end
      if (r_ps[8] !== 4'b0000)   begin errors++; $display("FAIL lvl_stall.ps2_early got=%b exp=0000", r_ps[8]); end
      if (r_done[16] !== 1'b1)   begin errors++; $display("FAIL lvl_stall.done got=%0b exp=1", r_done[16]); end
      $display("test_lvl_stall done");
   endtask

   task automatic test_start_ignored();
      int done_count = 0;
      clear_stim();
      st_start[0]  = 1'b1;
      st_start[4]  = 1'b1;
      st_start[13] = 1'b1;
      run_cycles("start_ignored", 30);
      for (int c = 0; c < 30; c++) if (r_done[c] === 1'b1) done_count++;
      checks += 2;
      if (done_count != 1)     begin errors++; $display("FAIL start_ignored.done_count got=%0d exp=1", done_count); end
      if (r_done[13] !== 1'b1) begin errors++; $display("FAIL start_ignored.done_cycle got=%0b exp=1", r_done[13]); end
      for (int c = 14; c < 30; c++) begin
         checks += 2;
         if (r_busy[c] !== 1'b0) begin errors++; $display("FAIL start_ignored.busy cyc=%0d got=%0b exp=0", c, r_busy[c]); end
         if (r_ps[c] !== '0)     begin errors++; $display("FAIL start_ignored.pack_start cyc=%0d got=%b exp=0", c, r_ps[c]); end
      end
      $display("test_start_ignored done");
   endtask

   task automatic test_reset_mid_pass();
      clear_stim();
      st_start[0] = 1'b1;
      st_nrst[7]  = 1'b0;
      st_nrst[8]  = 1'b0;
      run_cycles("reset_mid", 20);
      for (int c = 7; c <= 8; c++) begin
         checks += 5;
         if (r_busy[c] !== 1'b0) begin errors++; $display("FAIL reset_mid.busy cyc=%0d got=%0b exp=0", c, r_busy[c]); end
         if (r_lreq[c] !== 1'b0) begin errors++; $display("FAIL reset_mid.lvl_req cyc=%0d got=%0b exp=0", c, r_lreq[c]); end
         if (r_accv[c] !== 1'b0) begin errors++; $display("FAIL reset_mid.acc_valid cyc=%0d got=%0b exp=0", c, r_accv[c]); end
         if (r_lidx[c] !== '0)   begin errors++; $display("FAIL reset_mid.lvl_idx cyc=%0d got=%0d exp=0", c, r_lidx[c]); end
         if (r_ps[c] !== '0)     begin errors++; $display("FAIL reset_mid.pack_start cyc=%0d got=%b exp=0", c, r_ps[c]); end
      end
      for (int c = 7; c < 20; c++) begin
         checks += 2;
         if (r_done[c] !== 1'b0) begin errors++; $display("FAIL reset_mid.done cyc=%0d got=%0b exp=0", c, r_done[c]); end
         if (r_busy[c] !== 1'b0) begin errors++; $display("FAIL reset_mid.idle cyc=%0d got=%0b exp=0", c, r_busy[c]); end
      end
      // fresh pass restarts from pack 0
      clear_stim();
      st_start[0] = 1'b1;
      run_cycles("restart", 6);
      checks += 5;
      if (r_lreq[1] !== 1'b1)   begin errors++; $display("FAIL restart.lvl_req got=%0b exp=1", r_lreq[1]); end
      if (r_lidx[1] !== '0)     begin errors++; $display("FAIL restart.lvl_idx got=%0d exp=0", r_lidx[1]); end
      if (r_ps[2] !== 4'b0001)  begin errors++; $display("FAIL restart.pack_start got=%b exp=0001", r_ps[2]); end
      if (r_accv[3] !== 1'b1)   begin errors++; $display("FAIL restart.acc_valid got=%0b exp=1", r_accv[3]); end
      if (r_aidx[3] !== '0)     begin errors++; $display("FAIL restart.acc_idx got=%0d exp=0", r_aidx[3]); end
      // let the restarted pass finish so the DUT is idle afterwards
      clear_stim();
      run_cycles("restart_tail", 12);
      $display("test_reset_mid_pass done");
   endtask

`ifdef ENC_SCHED_ABORT_EN
   task automatic test_abort();
      bus3.enc_start = 1'b0;
      bus3.lvl_valid = 1'b1;
      bus3.acc_ready = 1'b1;
      bus3.enc_abort = 1'b0;
      for (int c = 0; c < 25; c++) begin
         bus3.enc_start = (c == 0);
         bus3.enc_abort = (c == 13);
         @(negedge clk);
         if (c == 12) begin
            checks++;
            if (bus3.pack_start !== 4'b0100) begin errors++; $display("FAIL abort.ps2 got=%b exp=0100", bus3.pack_start); end
         end
         if (c == 13) begin
            checks++;
            if (bus3.enc_busy !== 1'b1) begin errors++; $display("FAIL abort.busy_before got=%0b exp=1", bus3.enc_busy); end
         end
         if (c >= 13) begin
            checks++;
            if (bus3.pack_start !== '0) begin errors++; $display("FAIL abort.pack_start cyc=%0d got=%b exp=0", c, bus3.pack_start); end
         end
         if (c >= 14) begin
            checks += 3;
            if (bus3.enc_busy !== 1'b0) begin errors++; $display("FAIL abort.busy cyc=%0d got=%0b exp=0", c, bus3.enc_busy); end
            if (bus3.enc_done !== 1'b0) begin errors++; $display("FAIL abort.done cyc=%0d got=%0b exp=0", c, bus3.enc_done); end
            if (bus3.enc_aborted !== (c == 14)) begin errors++; $display("FAIL abort.aborted cyc=%0d got=%0b exp=%0b", c, bus3.enc_aborted, (c == 14)); end
         end
         @(posedge clk);
         #1;
      end
      bus3.enc_start = 1'b0;
      bus3.enc_abort = 1'b0;
      $display("test_abort done");
   endtask
`endif

   initial begin
      bus.enc_start = 1'b0;
      bus.lvl_valid = 1'b1;
      bus.acc_ready = 1'b1;
`ifdef ENC_SCHED_ABORT_EN
      bus.enc_abort  = 1'b0;
      bus3.enc_start = 1'b0;
      bus3.lvl_valid = 1'b1;
      bus3.acc_ready = 1'b1;
      bus3.enc_abort = 1'b0;
`endif
      test_reset();
      test_nominal();
      test_acc_stall();
      test_lvl_stall();
      test_start_ignored();
      test_reset_mid_pass();
`ifdef ENC_SCHED_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
